// File: rtl/bcd_a_bin_seq.sv
// Sequential packed-BCD to binary converter, one digit per clock, MS digit first.
// Optional invalid-digit detection is enabled by defining BCD_CHECK_EN.
module bcd_a_bin_seq #(
  parameter int DIGITS = 6,
  parameter int OUT_W  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_W-1:0]      bin_out,
  output logic                  error
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int ACC_W = OUT_W + 4;

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state;
  logic [4*DIGITS-1:0] shreg;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_next;
  logic [IDX_W-1:0]    idx;
  logic [3:0]          digit;

  // The operand shifts left each step so the digit being folded in is always the top nibble.
  assign digit    = shreg[4*DIGITS-1 -: 4];
  assign acc_next = (acc << 3) + (acc << 1) + ACC_W'(digit);

`ifdef BCD_CHECK_EN
  logic bad_flag;
  logic bad_now;

  assign bad_now = bad_flag | (digit > 4'd9);
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      acc     <= '0;
      idx     <= '0;
      shreg   <= '0;
`ifdef BCD_CHECK_EN
      error    <= 1'b0;
      bad_flag <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= bcd_in;
            acc   <= '0;
            idx   <= IDX_W'(DIGITS - 1);
            busy  <= 1'b1;
            state <= CONV;
`ifdef BCD_CHECK_EN
            bad_flag <= 1'b0;
`endif
          end
        end
        CONV: begin
          acc   <= acc_next;
          shreg <= shreg << 4;
`ifdef BCD_CHECK_EN
          bad_flag <= bad_now;
`endif
          if (idx == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef BCD_CHECK_EN
            error   <= bad_now;
            bin_out <= bad_now ? '0 : acc_next[OUT_W-1:0];
`else
            bin_out <= acc_next[OUT_W-1:0];
`endif
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_a_bin_seq.sv
// Scoreboard bench for bcd_a_bin_seq: stimulus pushes expected results, a negedge monitor
// pops and compares value, error flag and latency whenever done is seen.
module tb_bcd_a_bin_seq;

  localparam int DIGITS = 6;
  localparam int OUT_W  = 20;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [4*DIGITS-1:0] bcd_in = '0;
  logic               busy;
  logic               done;
  logic [OUT_W-1:0]   bin_out;
  logic               error;

  typedef struct {
    logic [OUT_W-1:0] bin;
    logic             err;
    int               due;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  int               k;
  logic [OUT_W-1:0] last_bin = '0;

  bcd_a_bin_seq #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pops one expectation; between dones the result must hold still.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_bin = '0;
    end else if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pending conversion (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("bin_out", 32'(bin_out), 32'(mon_e.bin));
        checkOutput("error", 32'(error), 32'(mon_e.err));
        checkOutput("latency_cycle", 32'(cyc), 32'(mon_e.due));
        checkOutput("busy_at_done", 32'(busy), 32'd0);
      end
      last_bin = bin_out;
    end else begin
      checkOutput("bin_out_stable", 32'(bin_out), 32'(last_bin));
    end
  end

  task automatic waitDrain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got %0d results pending, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [4*DIGITS-1:0] bcd, input logic [OUT_W-1:0] exp_bin,
                               input logic exp_err);
    @(negedge clk);
    bcd_in = bcd;
    start  = 1'b1;
    sb.push_back('{exp_bin, exp_err, cyc + DIGITS + 1});
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 24'h555555;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    waitDrain();
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_bin_out", 32'(bin_out), 32'd0);
    checkOutput("reset_error", 32'(error), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_bin_out", 32'(bin_out), 32'd0);
    checkOutput("idle_error", 32'(error), 32'd0);

    applyStimulus(24'h999999, 20'hF423F, 1'b0);
    applyStimulus(24'h123456, 20'h1E240, 1'b0);
    applyStimulus(24'h000000, 20'h00000, 1'b0);
`ifdef BCD_CHECK_EN
    applyStimulus(24'h12A456, 20'h00000, 1'b1);
    applyStimulus(24'h000001, 20'h00001, 1'b0);
`else
    applyStimulus(24'h12A456, 20'h1FD98, 1'b0);
`endif

    // start held high: back-to-back conversions every DIGITS+1 cycles, operand latched per run
    @(negedge clk);
    k      = cyc;
    bcd_in = 24'h000010;
    start  = 1'b1;
    sb.push_back('{20'h0000A, 1'b0, k + 7});
    sb.push_back('{20'h00014, 1'b0, k + 14});
    repeat (3) @(negedge clk);
    bcd_in = 24'h000020;
    repeat (5) @(negedge clk);
    start = 1'b0;
    checkOutput("busy_second_run", 32'(busy), 32'd1);
    waitDrain();

    // reset mid-conversion discards the partial result and suppresses done
    @(negedge clk);
    bcd_in = 24'h123456;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_bin_out", 32'(bin_out), 32'd0);
    checkOutput("midreset_error", 32'(error), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("post_reset_bin_out", 32'(bin_out), 32'd0);
    applyStimulus(24'h000007, 20'h00007, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
